// File: rtl/ifmap_stream_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : ifmap_stream_packer_if
// Purpose  : Bundles the two data paths of the ifmap stream packer:
//            - source side : in_valid / in_data / in_ready handshake
//            - buffer side : write_en / out_data strobe and buf_full flag
// Modports : master - the packer (consumes the source, drives the buffer)
//            slave  - the environment (drives the source, models the buffer)
// Params   : DATA_WIDTH - raw ifmap word width; out_data is DATA_WIDTH+2
//            wide, {start_tag, end_tag, data}
// Revision : 1.0 - initial release
// ============================================================================
interface ifmap_stream_packer_if #(
  parameter int DATA_WIDTH = 32
);

  // Source handshake
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  // Circular-buffer write port
  logic                  buf_full;
  logic                  write_en;
  logic [DATA_WIDTH+1:0] out_data;

  modport master (
    input  in_valid,
    input  in_data,
    input  buf_full,
    output in_ready,
    output write_en,
    output out_data
  );

  modport slave (
    output in_valid,
    output in_data,
    output buf_full,
    input  in_ready,
    input  write_en,
    input  out_data
  );

endinterface
`default_nettype wire

// File: rtl/ifmap_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : ifmap_stream_packer
// Purpose  : Accepts a raw stream of ifmap words and writes them into the
//            downstream ifmap circular buffer, tagging each word with
//            row-boundary markers: out_data = {start_tag, end_tag, data}.
//            A transfer is num_rows rows of row_len words each and is
//            launched by a one-cycle start pulse.
// Ports    : clk        - single clock, rising edge
//            rst        - asynchronous reset, active low (0 = reset)
//            start      - launch pulse, honoured only while idle
//            row_len    - words per row, captured on accepted start
//            num_rows   - rows per transfer, captured on accepted start
//            bus        - ifmap_stream_packer_if.master: in_valid, in_data,
//                         in_ready (source) and buf_full, write_en,
//                         out_data (buffer)
//            busy       - high from accepted start until done
//            done       - one-cycle pulse in the final cycle of a transfer
//            words_sent - (IFMAP_PACKER_STATS_EN only) saturating 16-bit
//                         count of write_en pulses since reset
// Options  : define IFMAP_PACKER_STATS_EN to add the words_sent counter port
// Revision : 1.0 - initial release
// ============================================================================
module ifmap_stream_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  wire                   clk,
  input  wire                   rst,
  input  wire                   start,
  input  wire   [LEN_WIDTH-1:0] row_len,
  input  wire   [LEN_WIDTH-1:0] num_rows,
  ifmap_stream_packer_if.master bus,
  output logic                  busy,
  output logic                  done
`ifdef IFMAP_PACKER_STATS_EN
  ,
  output logic           [15:0] words_sent
`endif
);

  // --------------------------------------------------------------------------
  // Types and constants
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] C_LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] C_LEN_ZERO = '0;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                state_q,    state_d;
  logic [LEN_WIDTH-1:0]  row_len_q,  row_len_d;
  logic [LEN_WIDTH-1:0]  num_rows_q, num_rows_d;
  logic [LEN_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [LEN_WIDTH-1:0]  row_cnt_q,  row_cnt_d;
  logic                  write_en_q, write_en_d;
  logic [DATA_WIDTH+1:0] out_data_q, out_data_d;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic w_in_ready;
  logic w_accept;
  logic w_first_word;
  logic w_last_word;
  logic w_last_row;
  logic w_zero_len;

  // buf_full gates acceptance directly, so a full buffer stalls the source in
  // the same cycle and the counters simply do not advance.
  assign w_in_ready   = (state_q == S_STREAM) && !bus.buf_full;
  assign w_accept     = w_in_ready && bus.in_valid;

  // Tags are derived from the counters as they stand when the word is
  // accepted; a one-word row satisfies both compares at once.
  assign w_first_word = (word_cnt_q == C_LEN_ZERO);
  assign w_last_word  = (word_cnt_q == (row_len_q - C_LEN_ONE));
  assign w_last_row   = (row_cnt_q  == (num_rows_q - C_LEN_ONE));

  // The values being latched this cycle are the live inputs, so the empty
  // transfer check looks at them rather than at the (stale) registers.
  assign w_zero_len   = (row_len == C_LEN_ZERO) || (num_rows == C_LEN_ZERO);

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    row_len_d  = row_len_q;
    num_rows_d = num_rows_q;
    word_cnt_d = word_cnt_q;
    row_cnt_d  = row_cnt_q;
    write_en_d = 1'b0;
    out_data_d = out_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_len_d  = row_len;
          num_rows_d = num_rows;
          word_cnt_d = C_LEN_ZERO;
          row_cnt_d  = C_LEN_ZERO;
          // An empty transfer skips streaming entirely and only pulses done.
          state_d    = w_zero_len ? S_FINISH : S_STREAM;
        end
      end

      S_STREAM: begin
        if (w_accept) begin
          write_en_d = 1'b1;
          out_data_d = {w_first_word, w_last_word, bus.in_data};
          if (w_last_word) begin
            word_cnt_d = C_LEN_ZERO;
            if (w_last_row) begin
              // The final word's write strobe lands in the FINISH cycle, so
              // write_en and done coincide.
              state_d = S_FINISH;
            end else begin
              row_cnt_d = row_cnt_q + C_LEN_ONE;
            end
          end else begin
            word_cnt_d = word_cnt_q + C_LEN_ONE;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      row_len_q  <= '0;
      num_rows_q <= '0;
      word_cnt_q <= '0;
      row_cnt_q  <= '0;
      write_en_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      row_len_q  <= row_len_d;
      num_rows_q <= num_rows_d;
      word_cnt_q <= word_cnt_d;
      row_cnt_q  <= row_cnt_d;
      write_en_q <= write_en_d;
      out_data_q <= out_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // busy and done decode the state register directly, so the asynchronous
  // reset clears them in the same instant as the flops.
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FINISH);
  assign bus.in_ready = w_in_ready;
  assign bus.write_en = write_en_q;
  assign bus.out_data = out_data_q;

  // --------------------------------------------------------------------------
  // Optional write statistics
  // --------------------------------------------------------------------------
`ifdef IFMAP_PACKER_STATS_EN
  logic [15:0] words_sent_q, words_sent_d;

  // Counts the visible write strobes; sticks at all-ones instead of wrapping.
  always_comb begin
    words_sent_d = words_sent_q;
    if (write_en_q && (words_sent_q != 16'hFFFF)) begin
      words_sent_d = words_sent_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_sent_q <= 16'd0;
    end else begin
      words_sent_q <= words_sent_d;
    end
  end

  assign words_sent = words_sent_q;
`endif

endmodule
`default_nettype wire
